// File: rtl/pv1000_mem_arbiter.sv
// pv1000_mem_arbiter: shares the single synchronous system RAM port between
// cartridge download writes, the CPU and the VDP. It also stretches the
// console reset across a download and for a fixed time after it.
//
// Handshake (CPU and VDP): the requester raises req with we/addr/wdata and
// holds them stable. The access is issued in the cycle the arbiter grants it.
// ack pulses for one cycle in the following cycle, together with rdata.
// A req level seen in the ack cycle is a new request, but the arbiter never
// grants a requester whose own ack is still pending. So each requester gets
// at most one access every two cycles.
module pv1000_mem_arbiter #(
    parameter int AW             = 16,
    parameter int DW             = 8,
    parameter int VDP_MAX_WAIT   = 4,
    parameter int POST_DL_CYCLES = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dl_active,
    input  logic          dl_wr,
    input  logic [AW-1:0] dl_addr,
    input  logic [DW-1:0] dl_data,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          vdp_req,
    input  logic [AW-1:0] vdp_addr,
    output logic          vdp_ack,
    output logic [DW-1:0] vdp_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          hold_reset,
    output logic [1:0]    o_dbg_state
);

    localparam logic [3:0] LP_MAX_WAIT = 4'(VDP_MAX_WAIT);
    localparam logic [7:0] LP_POST_DL  = 8'(POST_DL_CYCLES);

    // Pending-ack state: records which requester, if any, was issued last cycle.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACK_CPU = 2'd1,
        ST_ACK_VDP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_DL   = 2'd1,
        GNT_CPU  = 2'd2,
        GNT_VDP  = 2'd3
    } grant_t;

    state_t          r_state;
    logic [3:0]      r_wait_cnt;
    logic [7:0]      r_hcnt;
    logic [AW-1:0]   r_last_addr;
    logic [DW-1:0]   r_cpu_rdata;
    logic [DW-1:0]   r_vdp_rdata;

    grant_t          w_gnt;
    logic            w_cpu_busy;
    logic            w_vdp_busy;
    logic            w_cpu_ack;
    logic            w_vdp_ack;

    assign w_cpu_busy = (r_state == ST_ACK_CPU);
    assign w_vdp_busy = (r_state == ST_ACK_VDP);

    // A pending ack that coincides with reset is dropped rather than delivered.
    assign w_cpu_ack = w_cpu_busy && !reset;
    assign w_vdp_ack = w_vdp_busy && !reset;

    // Pick this cycle's winner; a requester with its own ack pending is skipped.
    always_comb begin
        w_gnt = GNT_NONE;
        if (reset) begin
            w_gnt = GNT_NONE;
        end else if (dl_active) begin
            if (dl_wr) begin
                w_gnt = GNT_DL;
            end
        end else if (vdp_req && (r_wait_cnt >= LP_MAX_WAIT) && !w_vdp_busy) begin
            w_gnt = GNT_VDP;
        end else if (cpu_req && !w_cpu_busy) begin
            w_gnt = GNT_CPU;
        end else if (vdp_req && !w_vdp_busy) begin
            w_gnt = GNT_VDP;
        end
    end

    // Drive the RAM port from the winner; with no winner the address is parked.
    always_comb begin
        mem_addr  = r_last_addr;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (w_gnt)
            GNT_DL: begin
                mem_addr  = dl_addr;
                mem_we    = 1'b1;
                mem_wdata = dl_data;
            end
            GNT_CPU: begin
                mem_addr  = cpu_addr;
                mem_we    = cpu_we;
                mem_wdata = cpu_wdata;
            end
            GNT_VDP: begin
                mem_addr  = vdp_addr;
            end
            default: begin
                if (reset) begin
                    mem_addr = '0;
                end
            end
        endcase
    end

    // Remember the last driven address so idle cycles hold it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_addr <= '0;
        end else begin
            r_last_addr <= mem_addr;
        end
    end

    // Pending-ack FSM and the VDP starvation counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
        end else begin
            case (w_gnt)
                GNT_CPU: r_state <= ST_ACK_CPU;
                GNT_VDP: r_state <= ST_ACK_VDP;
                default: r_state <= ST_IDLE;
            endcase
            if (!vdp_req || (w_gnt == GNT_VDP)) begin
                r_wait_cnt <= 4'd0;
            end else if (r_wait_cnt != 4'hF) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
        end
    end

    // Capture read data in the ack cycle so it stays visible afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cpu_rdata <= '0;
            r_vdp_rdata <= '0;
        end else begin
            if (w_cpu_ack && !cpu_we) begin
                r_cpu_rdata <= mem_rdata;
            end
            if (w_vdp_ack) begin
                r_vdp_rdata <= mem_rdata;
            end
        end
    end

    // Post-download reset stretch: reload while loading, then count down.
    always_ff @(posedge clk) begin
        if (reset || dl_active) begin
            r_hcnt <= LP_POST_DL;
        end else if (r_hcnt != 8'd0) begin
            r_hcnt <= r_hcnt - 8'd1;
        end
    end

    assign cpu_ack     = w_cpu_ack;
    assign vdp_ack     = w_vdp_ack;
    assign cpu_rdata   = reset ? '0 : ((w_cpu_ack && !cpu_we) ? mem_rdata : r_cpu_rdata);
    assign vdp_rdata   = reset ? '0 : (w_vdp_ack ? mem_rdata : r_vdp_rdata);
    assign hold_reset  = dl_active | (r_hcnt != 8'd0);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pv1000_mem_arbiter.sv
// Directed bench for pv1000_mem_arbiter with a behavioural synchronous RAM.
// Expected read data is queued when a request is issued; a monitor process
// pops and compares on every ack.
module tb_pv1000_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dl_active = 1'b0;
  logic        dl_wr = 1'b0;
  logic [15:0] dl_addr = '0;
  logic [7:0]  dl_data = '0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        vdp_req = 1'b0;
  logic [15:0] vdp_addr = '0;
  logic        vdp_ack;
  logic [7:0]  vdp_rdata;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        hold_reset;
  logic [1:0]  dbg_state;

  logic [7:0]  ram [0:65535];
  logic [7:0]  cpu_exp_q[$];
  logic [7:0]  vdp_exp_q[$];
  logic [7:0]  cpu_hold_model = 8'h00;
  int          n_vec = 0;
  int          n_err = 0;

  pv1000_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .vdp_req(vdp_req), .vdp_addr(vdp_addr), .vdp_ack(vdp_ack), .vdp_rdata(vdp_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .hold_reset(hold_reset), .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // synchronous RAM, one cycle read latency
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (cpu_ack === 1'b1) begin
      if (cpu_exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL cpu_ack_unexpected: got ack with rdata 0x%0h expected no ack", cpu_rdata);
      end else begin
        check("cpu_rdata_sb", 32'(cpu_rdata), 32'(cpu_exp_q.pop_front()));
      end
    end
    if (vdp_ack === 1'b1) begin
      if (vdp_exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL vdp_ack_unexpected: got ack with rdata 0x%0h expected no ack", vdp_rdata);
      end else begin
        check("vdp_rdata_sb", 32'(vdp_rdata), 32'(vdp_exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_access(input logic we, input logic [15:0] a, input logic [7:0] d,
                            input logic [7:0] exp_rd, input string nm);
    bit got;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    cpu_exp_q.push_back(we ? cpu_hold_model : exp_rd);
    if (!we) cpu_hold_model = exp_rd;
    @(negedge clk);
    check({nm, "_issue_addr"}, 32'(mem_addr), 32'(a));
    check({nm, "_issue_we"}, 32'(mem_we), 32'(we));
    got = 1'b0;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk);
      if (cpu_ack === 1'b1) got = 1'b1;
    end
    check({nm, "_ack_seen"}, 32'(got), 32'd1);
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  initial begin
    int first_vdp;
    int gap;
    int max_gap;
    int nwe;

    // reset values
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) begin
        check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rst_vdp_ack", 32'(vdp_ack), 32'd0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        check("rst_vdp_rdata", 32'(vdp_rdata), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_hold_reset", 32'(hold_reset), 32'd1);
      end
    end
    tick();
    reset = 1'b0;
    tick();

    // preload through the CPU port; write acks leave rdata at its reset value
    cpu_access(1'b1, 16'h1234, 8'h5A, 8'h00, "pre_1234");
    cpu_access(1'b1, 16'h2000, 8'h77, 8'h00, "pre_2000");
    cpu_access(1'b1, 16'h3000, 8'h99, 8'h00, "pre_3000");

    // CPU read, then rdata held after req drops
    cpu_access(1'b0, 16'h1234, 8'h00, 8'h5A, "rd_1234");
    tick();
    @(negedge clk);
    check("rd_1234_held", 32'(cpu_rdata), 32'h5A);

    // CPU write keeps rdata, then read back
    tick();
    cpu_access(1'b1, 16'h00FF, 8'hA5, 8'h00, "wr_00ff");
    @(negedge clk);
    check("wr_00ff_rdata_kept", 32'(cpu_rdata), 32'h5A);
    tick();
    cpu_access(1'b0, 16'h00FF, 8'h00, 8'hA5, "rd_00ff");

    // contention: CPU first, then strict alternation
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2000;
    vdp_req = 1'b1; vdp_addr = 16'h3000;
    for (int i = 0; i < 20; i++) begin
      cpu_exp_q.push_back(8'h77);
      vdp_exp_q.push_back(8'h99);
    end
    cpu_hold_model = 8'h77;
    first_vdp = -1; gap = 0; max_gap = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) check("cont_first_is_cpu", 32'(mem_addr), 32'h2000);
      if (vdp_ack === 1'b1) begin
        if (first_vdp < 0) first_vdp = c;
        gap = 0;
      end else begin
        gap++;
        if (gap > max_gap) max_gap = gap;
      end
    end
    tick();
    cpu_req = 1'b0; vdp_req = 1'b0;
    check("cont_first_vdp_ack_cycle", 32'(first_vdp), 32'd2);
    check("cont_max_vdp_gap", 32'(max_gap), 32'd2);
    tick();

    // download with both requesters waiting; VDP wins first after dl falls
    tick();
    dl_active = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0000;
    vdp_req = 1'b1; vdp_addr = 16'h0002;
    nwe = 0;
    for (int i = 0; i < 9; i++) begin
      dl_wr = (i == 2) || (i == 4) || (i == 6);
      dl_addr = 16'((i - 2) / 2);
      dl_data = (i == 2) ? 8'h11 : (i == 4) ? 8'h22 : 8'h33;
      @(negedge clk);
      if (mem_we === 1'b1) nwe++;
      if (i == 0) check("dl_hold_reset", 32'(hold_reset), 32'd1);
      tick();
    end
    dl_wr = 1'b0;
    dl_active = 1'b0;
    vdp_exp_q.push_back(8'h33);
    cpu_exp_q.push_back(8'h11);
    cpu_hold_model = 8'h11;
    check("dl_write_count", 32'(nwe), 32'd3);
    @(negedge clk);
    check("post_dl_vdp_priority", 32'(mem_addr), 32'h0002);
    @(negedge clk);
    check("post_dl_vdp_ack", 32'(vdp_ack), 32'd1);
    tick();
    vdp_req = 1'b0;
    @(negedge clk);
    check("post_dl_cpu_ack", 32'(cpu_ack), 32'd1);
    tick();
    cpu_req = 1'b0;
    for (int i = 0; i < 252; i++) @(negedge clk);
    check("hold_reset_last_high", 32'(hold_reset), 32'd1);
    @(negedge clk);
    check("hold_reset_released", 32'(hold_reset), 32'd0);
    tick();
    cpu_access(1'b0, 16'h0001, 8'h00, 8'h22, "rd_0001");
    cpu_access(1'b0, 16'h0002, 8'h00, 8'h33, "rd_0002");

    // dl_active rises while a CPU read is in flight
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    cpu_exp_q.push_back(8'h5A);
    cpu_hold_model = 8'h5A;
    @(negedge clk);
    tick();
    dl_active = 1'b1;
    @(negedge clk);
    check("dl_rise_ack_kept", 32'(cpu_ack), 32'd1);
    for (int i = 0; i < 6; i++) @(negedge clk);
    tick();
    cpu_req = 1'b0;
    tick();
    dl_active = 1'b0;
    tick();

    // reset during a pending VDP ack
    tick();
    vdp_req = 1'b1; vdp_addr = 16'h2000;
    @(negedge clk);
    check("rst_mid_issue_addr", 32'(mem_addr), 32'h2000);
    tick();
    reset = 1'b1;
    vdp_req = 1'b0;
    @(negedge clk);
    check("rst_mid_no_vdp_ack", 32'(vdp_ack), 32'd0);
    tick();
    reset = 1'b0;
    cpu_hold_model = 8'h00;
    @(negedge clk);
    check("rst_mid_vdp_rdata", 32'(vdp_rdata), 32'd0);
    check("rst_mid_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_mid_mem_we", 32'(mem_we), 32'd0);
    check("rst_mid_hold_reset", 32'(hold_reset), 32'd1);
    tick();
    cpu_access(1'b0, 16'h1234, 8'h00, 8'h5A, "rd_after_rst");

    // drain and report
    for (int i = 0; i < 4; i++) @(negedge clk);
    check("cpu_exp_q_drained", 32'(cpu_exp_q.size()), 32'd0);
    check("vdp_exp_q_drained", 32'(vdp_exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pv1000_mem_arbiter.md
Name: pv1000_mem_arbiter

Overview:
- Shares the single system RAM port between three requesters.
  - HPS cartridge download writes.
  - CPU reads and writes.
  - VDP fetches.
- Sits between the console core and the RAM instance, replacing the download/CPU address mux in the top level.
- Also generates the post-download reset stretch that holds the console in reset while a cartridge loads and for a fixed time afterwards.

Parameters:
AW, 16, address width of RAM and all requester address buses
DW, 8, data width
VDP_MAX_WAIT, 4, consecutive denied cycles after which a pending VDP request takes priority over the CPU (1..15)
POST_DL_CYCLES, 255, cycles hold_reset stays high after dl_active falls (1..255)

Ports:
clk  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous active-high reset
dl_active  in  1  download in progress (from ioctl_download)
dl_wr  in  1  one-cycle download write strobe
dl_addr  in  AW  download write address
dl_data  in  DW  download write data
cpu_req  in  1  CPU access request, level
cpu_we  in  1  1 = write, 0 = read; valid with cpu_req
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DW  CPU read data; valid in the ack cycle, held afterwards
vdp_req  in  1  VDP read request, level
vdp_addr  in  AW  VDP address
vdp_ack  out  1  one-cycle completion pulse
vdp_rdata  out  DW  VDP read data; valid in the ack cycle, held afterwards
mem_addr  out  AW  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  DW  RAM write data
mem_rdata  in  DW  RAM read data; synchronous RAM, 1-cycle latency
hold_reset  out  1  console reset request

Behaviour:
- One RAM access is issued per cycle.
- mem_addr, mem_we and mem_wdata are combinational from the current cycle's winner.
- Access issued in cycle N: mem_rdata is valid in N+1, and the winner's ack pulses in N+1.
- cpu_rdata and vdp_rdata show mem_rdata in the ack cycle and are registered to hold that value afterwards.
- A write also acks in N+1; its rdata is unchanged.
- Priority in each cycle, first match wins:
  - (1) dl_active: issue a write only if dl_wr, with mem_addr=dl_addr, mem_wdata=dl_data, mem_we=1. CPU and VDP are never granted while dl_active.
  - (2) vdp_req and wait_cnt >= VDP_MAX_WAIT: VDP.
  - (3) cpu_req: CPU.
  - (4) vdp_req: VDP.
  - (5) none: mem_we=0 and mem_addr holds its previous value.
- A requester is not granted in a cycle where its own access is in flight (issued in the previous cycle, ack pending). Its req level in the ack cycle counts as a new request, so the maximum rate is one access per 2 cycles per requester.
- wait_cnt (4 bits):
  - Cleared when the VDP is granted or vdp_req=0.
  - Incremented, saturating at 15, in each cycle vdp_req=1 and the VDP is not granted, including while dl_active.
- States (pending ack): IDLE, ACK_CPU, ACK_VDP. The next state is set from the current cycle's grant. Download writes produce no ack.
- dl_active rising while an access is in flight: that access's ack and rdata are still delivered in the next cycle.
- hold_reset:
  - 8-bit counter hcnt, loaded with POST_DL_CYCLES while reset or dl_active is high, otherwise decremented to 0.
  - hold_reset = dl_active | (hcnt != 0).
- Requesters must hold req, we, addr and wdata stable until their ack. A req dropped before ack is a protocol violation; its result is undefined but must not corrupt the other requesters.
- Reset values:
  - cpu_ack=0, vdp_ack=0, cpu_rdata=0, vdp_rdata=0.
  - state=IDLE, wait_cnt=0, hcnt=POST_DL_CYCLES, hold_reset=1.
  - mem_we is forced 0 during reset, and mem_addr is held at 0 during reset.
- Reset asserted with an access in flight: the pending ack is discarded and no ack is issued after reset.

Test Plan:
- CPU read: cpu_req=1, cpu_we=0, addr 0x1234 where RAM holds 0x5A, at cycle N -> mem_addr=0x1234 at N; cpu_ack=1 and cpu_rdata=0x5A at N+1; cpu_rdata stays 0x5A after cpu_req drops.
- Contention with default VDP_MAX_WAIT=4: cpu_req held high with back-to-back reads, vdp_req held from cycle 0 -> first VDP grant no later than cycle 4 (wait_cnt reaches 4), then CPU grants resume; VDP never denied more than 4 consecutive cycles.
- Download: dl_active=1 with dl_wr pulses writing 0x11,0x22,0x33 to 0x0000-0x0002 while cpu_req=1 -> 3 writes with mem_we=1, no cpu_ack during dl_active; hold_reset=1 during download and for 255 cycles after dl_active falls, then 0; reading back returns 0x11,0x22,0x33.
- dl_active rising in the cycle a CPU read is in flight -> that cpu_ack still pulses next cycle with correct data; no further CPU grants until dl_active falls.
- Reset mid-access: reset asserted in cycle N+1 of a VDP read -> no vdp_ack; vdp_rdata=0, mem_we=0, hold_reset=1 after reset; a subsequent read behaves as in the CPU read scenario.
- CPU write 0xA5 to 0x00FF, then read of 0x00FF -> write acks 1 cycle after issue with cpu_rdata unchanged; read returns 0xA5.
